serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl
// ----------------------------------------------------------------------------
// Bit-serial adder controller. One external combinational full adder is
// sequenced LSB-first, one bit per clock. An IDLE -> RUN -> DONE state machine
// loads the operands, streams the bits through the full adder, and assembles
// the sum in a shift register.
//
// Optional feature (macro SERIAL_ADD_SUB_EN):
//   Adds input port `sub`. When sub=1 at start acceptance, ~op_b is loaded and
//   the carry is forced to 1, so the block computes op_a - op_b. In that case
//   cout=1 means no borrow occurred.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request to begin; accepted in IDLE or DONE, ignored in RUN
//   op_a      in   [WIDTH] addend A
//   op_b      in   [WIDTH] addend B
//   cin       in   carry-in
//   sub       in   subtract select (only with SERIAL_ADD_SUB_EN)
//   fa_a      out  A bit to the full adder (0 outside RUN)
//   fa_b      out  B bit to the full adder (0 outside RUN)
//   fa_c      out  carry bit to the full adder (0 outside RUN)
//   fa_sum    in   sum bit from the full adder
//   fa_carry  in   carry bit from the full adder
//   busy      out  high in RUN
//   done      out  one-cycle pulse in DONE
//   result    out  [WIDTH] sum; held until the next accepted start
//   cout      out  final carry-out; held until the next accepted start
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;

    // Start is honoured only outside RUN; last_s marks the final bit edge.
    always_comb begin
        accept_s = start && ((state_q == IDLE) || (state_q == DONE));
        last_s   = (state_q == RUN) && (cnt_q == LAST_CNT);
    end

    // Operand conditioning: subtraction is A + ~B + 1.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load_s = ~op_b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = op_b;
            c_load_s = cin;
        end
`else
        b_load_s = op_b;
        c_load_s = cin;
`endif
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = RUN;
                else          state_d = IDLE;
            end
            RUN: begin
                if (last_s) state_d = DONE;
                else        state_d = RUN;
            end
            DONE: begin
                if (accept_s) state_d = RUN;
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath: operand load on accept, one-bit shift per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            case (state_q)
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    // Sum enters at the MSB so bit 0 lands at position 0
                    // after WIDTH shifts.
                    res_q   <= {fa_sum, res_q[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_s) cout_q <= fa_carry;
                    else        cout_q <= cout_q;
                end
                IDLE, DONE: begin
                    if (accept_s) begin
                        a_q     <= op_a;
                        b_q     <= b_load_s;
                        res_q   <= {WIDTH{1'b0}};
                        carry_q <= c_load_s;
                        cout_q  <= 1'b0;
                        cnt_q   <= {CW{1'b0}};
                    end else begin
                        a_q     <= a_q;
                        b_q     <= b_q;
                        res_q   <= res_q;
                        carry_q <= carry_q;
                        cout_q  <= cout_q;
                        cnt_q   <= cnt_q;
                    end
                end
                default: begin
                    a_q     <= {WIDTH{1'b0}};
                    b_q     <= {WIDTH{1'b0}};
                    res_q   <= {WIDTH{1'b0}};
                    carry_q <= 1'b0;
                    cout_q  <= 1'b0;
                    cnt_q   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Full-adder operands are driven only in RUN, straight from registers.
    always_comb begin
        if (state_q == RUN) begin
            fa_a = a_q[0];
            fa_b = b_q[0];
            fa_c = carry_q;
        end else begin
            fa_a = 1'b0;
            fa_b = 1'b0;
            fa_c = 1'b0;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl
// Directed-vector bench with a scoreboard: each issued operation pushes its
// hand-computed {cout,result}, and a monitor pops and compares on every done.
// A behavioural full adder closes the loop on the fa_* ports.
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             fa_a;
    logic             fa_b;
    logic             fa_c;
    logic             fa_sum;
    logic             fa_carry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    int tests;
    int failed;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] mon_exp;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_c     (fa_c),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout)
    );

    // External combinational full adder.
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {24'd0, result}, {24'd0, mon_exp[WIDTH-1:0]});
                check("cout", {31'd0, cout}, {31'd0, mon_exp[WIDTH]});
            end
        end
    end

    // Issue one operation at the current negedge; start is held for one edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input logic [7:0] er, input logic ec,
                         input bit push);
        op_a  = a;
        op_b  = b;
        cin   = c;
`ifdef SERIAL_ADD_SUB_EN
        sub   = s;
`else
        if (s) $display("note: subtract vector skipped in default build");
`endif
        start = 1'b1;
        if (push) exp_q.push_back({ec, er});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done, counting RUN cycles and recording fa_c per bit.
    // inj_at>0: raise start with other operands in that RUN cycle.
    // inj_push: keep start high into DONE and expect the injected sum.
    task automatic wait_done(input int inj_at, input logic [7:0] ia, input logic [7:0] ib,
                             input bit inj_push, input logic [7:0] ier,
                             output int busy_cnt, output logic [7:0] fac_vec);
        bit seen;
        busy_cnt = 0;
        fac_vec  = 8'd0;
        seen     = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (busy) begin
                if (busy_cnt < WIDTH) fac_vec[busy_cnt] = fa_c;
                busy_cnt++;
                if (inj_at != 0 && busy_cnt == inj_at) begin
                    op_a  = ia;
                    op_b  = ib;
                    cin   = 1'b1;
                    start = 1'b1;
                    if (inj_push) begin
                        cin = 1'b0;
                        exp_q.push_back({1'b0, ier});
                    end
                end else if (inj_at != 0 && !inj_push && busy_cnt == inj_at + 1) begin
                    start = 1'b0;
                end
            end
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", busy_cnt, WIDTH);
    endtask

    int         bc;
    logic [7:0] fv;
    int         done_cnt;

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b1;
        start  = 1'b0;
        op_a   = 8'd0;
        op_b   = 8'd0;
        cin    = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub    = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 3 + 5 = 8
        issue(8'h03, 8'h05, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);

        // 0xFF + 0x01: carry ripples through bits 1..7
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        check("fa_c_pattern", {24'd0, fv}, 32'h0000_00FE);
        @(negedge clk);

        // 0xFF + 0xFF + 1, then start held through DONE with 0x10 + 0x20
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
        wait_done(WIDTH, 8'h10, 8'h20, 1'b1, 8'h30, bc, fv);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);

        // Start re-pulsed in the 3rd RUN cycle is ignored
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);
        wait_done(3, 8'hAA, 8'h55, 1'b0, 8'd0, bc, fv);
        @(negedge clk);
        check("no_queued_start", {31'd0, busy}, 32'd0);

        // Reset in the 4th RUN cycle aborts the operation
        issue(8'h44, 8'h11, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);

        // Additional patterns
        issue(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);
        issue(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);
        issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction: cin is ignored when sub=1
        issue(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);
        issue(8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1);
        wait_done(0, 8'd0, 8'd0, 1'b0, 8'd0, bc, fv);
        @(negedge clk);
        sub = 1'b0;
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
